traffic_light_controller_param: RTL and testbench

Parametrised two-road (highway / local road) signal controller that succeeds the fixed-timing controller. It adds configurable phase durations, latched car requests, local-road gap-out (early green termination) and a pedestrian walk phase. It also adds a flashing night mode. The block sits at top level, driving the light outputs directly from registered state.

---
 rtl/traffic_light_controller_param.sv | 216 +++++++++++++++++++++
 tb/tb_traffic_light_controller_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller_param.sv
// -----------------------------------------------------------------------------
// traffic_light_controller_param
// Two-road (highway / local road) signal controller. It has configurable phase
// durations, latched car and pedestrian requests, local-road gap-out, a
// pedestrian walk phase and a flashing night mode.
//
// Ports:
//   clk         clock
//   rst_n       synchronous, active-low reset
//   lr_has_car  local-road car sensor (level)
//   ped_req     pedestrian button (pulse or level)
//   flash       night/flash mode enable (level)
//   hw_light    highway light   {green, yellow, red}, 000 = off
//   lr_light    local-road light {green, yellow, red}, 000 = off
//   walk        pedestrian walk lamp
//   phase       current controller state (see state_t encoding)
//
// The lights and the walk lamp are registered. They are loaded from the decode
// of the next state, so they always match the state register and have no
// combinational path from the inputs.
// -----------------------------------------------------------------------------
module traffic_light_controller_param #(
    parameter int CNT_W        = 8,
    parameter int HW_GREEN_MIN = 70,
    parameter int YELLOW       = 25,
    parameter int ALL_RED      = 1,
    parameter int LR_GREEN_MIN = 10,
    parameter int LR_GREEN_MAX = 70,
    parameter int WALK_LEN     = 30,
    parameter int FLASH_HALF   = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lr_has_car,
    input  logic       ped_req,
    input  logic       flash,
    output logic [2:0] hw_light,
    output logic [2:0] lr_light,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_HW_G  = 3'd0,
        ST_HW_Y  = 3'd1,
        ST_AR1   = 3'd2,
        ST_WALK  = 3'd3,
        ST_LR_G  = 3'd4,
        ST_LR_Y  = 3'd5,
        ST_AR2   = 3'd6,
        ST_FLASH = 3'd7
    } state_t;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    // Last count value of each timed phase: a phase of N cycles exits at cnt == N-1.
    localparam logic [CNT_W-1:0] HW_G_LAST  = CNT_W'(HW_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] LR_MIN_LST = CNT_W'(LR_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] LR_MAX_LST = CNT_W'(LR_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_LEN - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             car_pend_r, car_pend_s;
    logic             ped_pend_r, ped_pend_s;
    logic             blink_r, blink_s;
    logic [2:0]       hw_light_r, lr_light_r;
    logic             walk_r;
    logic             enter_flash_s;

    // Packs {hw_light, lr_light, walk} for a given state and blink phase.
    function automatic logic [6:0] light_decode(input state_t st, input logic bl);
        logic [6:0] res;
        case (st)
            ST_HW_G:  res = {LIGHT_GREEN,  LIGHT_RED,    1'b0};
            ST_HW_Y:  res = {LIGHT_YELLOW, LIGHT_RED,    1'b0};
            ST_WALK:  res = {LIGHT_RED,    LIGHT_RED,    1'b1};
            ST_LR_G:  res = {LIGHT_RED,    LIGHT_GREEN,  1'b0};
            ST_LR_Y:  res = {LIGHT_RED,    LIGHT_YELLOW, 1'b0};
            ST_FLASH: res = bl ? {LIGHT_YELLOW, LIGHT_RED, 1'b0}
                               : {LIGHT_OFF,    LIGHT_OFF, 1'b0};
            default:  res = {LIGHT_RED,    LIGHT_RED,    1'b0};
        endcase
        return res;
    endfunction

    // Next-state selection. Flash has priority over every other transition.
    always_comb begin
        state_s = state_r;
        if (flash && (state_r != ST_FLASH)) begin
            state_s = ST_FLASH;
        end else begin
            case (state_r)
                ST_HW_G: begin
                    if ((cnt_r >= HW_G_LAST) && (car_pend_r || ped_pend_r)) state_s = ST_HW_Y;
                    else state_s = state_r;
                end
                ST_HW_Y: begin
                    if (cnt_r == YEL_LAST) state_s = ST_AR1;
                    else state_s = state_r;
                end
                ST_AR1: begin
                    if (cnt_r == AR_LAST) state_s = ped_pend_r ? ST_WALK : ST_LR_G;
                    else state_s = state_r;
                end
                ST_WALK: begin
                    if (cnt_r == WALK_LAST) state_s = car_pend_r ? ST_LR_G : ST_HW_G;
                    else state_s = state_r;
                end
                ST_LR_G: begin
                    // Max timeout and gap-out may coincide; both lead to the same yellow.
                    if ((cnt_r == LR_MAX_LST) || ((cnt_r >= LR_MIN_LST) && !lr_has_car))
                        state_s = ST_LR_Y;
                    else
                        state_s = state_r;
                end
                ST_LR_Y: begin
                    if (cnt_r == YEL_LAST) state_s = ST_AR2;
                    else state_s = state_r;
                end
                ST_AR2: begin
                    if (cnt_r == AR_LAST) state_s = ST_HW_G;
                    else state_s = state_r;
                end
                ST_FLASH: begin
                    if (!flash) state_s = ST_AR2;
                    else state_s = state_r;
                end
                default: state_s = ST_HW_G;
            endcase
        end
    end

    // Phase counter, blink phase and request latches; a clear on phase entry beats a set.
    always_comb begin
        cnt_s         = cnt_r;
        blink_s       = blink_r;
        car_pend_s    = car_pend_r;
        ped_pend_s    = ped_pend_r;
        enter_flash_s = (state_s == ST_FLASH) && (state_r != ST_FLASH);

        if (state_s != state_r) begin
            cnt_s = CNT_ZERO;
        end else if ((state_r == ST_FLASH) && (cnt_r == FLASH_LAST)) begin
            cnt_s = CNT_ZERO;
        end else if (cnt_r != CNT_MAX) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end

        if (enter_flash_s) begin
            blink_s = 1'b1;
        end else if ((state_r == ST_FLASH) && (state_s == ST_FLASH) && (cnt_r == FLASH_LAST)) begin
            blink_s = ~blink_r;
        end else begin
            blink_s = blink_r;
        end

        if (enter_flash_s) begin
            car_pend_s = 1'b0;
        end else if ((state_s == ST_LR_G) && (state_r != ST_LR_G)) begin
            car_pend_s = 1'b0;
        end else if (lr_has_car && !(state_r inside {ST_LR_G, ST_LR_Y, ST_FLASH})) begin
            car_pend_s = 1'b1;
        end else begin
            car_pend_s = car_pend_r;
        end

        if (enter_flash_s) begin
            ped_pend_s = 1'b0;
        end else if ((state_s == ST_WALK) && (state_r != ST_WALK)) begin
            ped_pend_s = 1'b0;
        end else if (ped_req && !(state_r inside {ST_WALK, ST_FLASH})) begin
            ped_pend_s = 1'b1;
        end else begin
            ped_pend_s = ped_pend_r;
        end
    end

    // State, counter, latches and registered light outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_HW_G;
            cnt_r      <= CNT_ZERO;
            car_pend_r <= 1'b0;
            ped_pend_r <= 1'b0;
            blink_r    <= 1'b1;
            hw_light_r <= LIGHT_GREEN;
            lr_light_r <= LIGHT_RED;
            walk_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            car_pend_r <= car_pend_s;
            ped_pend_r <= ped_pend_s;
            blink_r    <= blink_s;
            {hw_light_r, lr_light_r, walk_r} <= light_decode(state_s, blink_s);
        end
    end

    assign hw_light = hw_light_r;
    assign lr_light = lr_light_r;
    assign walk     = walk_r;
    assign phase    = state_r;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// -----------------------------------------------------------------------------
// Bench for traffic_light_controller_param: directed scenarios with explicit
// phase timing checks, then randomized inputs. Every cycle is compared against
// a behavioural model that tracks elapsed time per phase as a plain integer.
// -----------------------------------------------------------------------------
module tb_traffic_light_controller_param;

    localparam int CNT_W        = 8;
    localparam int HW_GREEN_MIN = 70;
    localparam int YELLOW       = 25;
    localparam int ALL_RED      = 1;
    localparam int LR_GREEN_MIN = 10;
    localparam int LR_GREEN_MAX = 70;
    localparam int WALK_LEN     = 30;
    localparam int FLASH_HALF   = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lr_has_car = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash = 1'b0;
    logic [2:0] hw_light, lr_light, phase;
    logic       walk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: phase number, cycles spent in phase so far (unbounded), request latches.
    int m_ph = 0;
    int m_t = 0;
    bit m_car = 1'b0;
    bit m_ped = 1'b0;

    traffic_light_controller_param #(
        .CNT_W(CNT_W), .HW_GREEN_MIN(HW_GREEN_MIN), .YELLOW(YELLOW), .ALL_RED(ALL_RED),
        .LR_GREEN_MIN(LR_GREEN_MIN), .LR_GREEN_MAX(LR_GREEN_MAX), .WALK_LEN(WALK_LEN),
        .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lr_has_car(lr_has_car), .ped_req(ped_req),
        .flash(flash), .hw_light(hw_light), .lr_light(lr_light), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Blink is on during the first half-period of every full flash period.
    function automatic bit m_blink();
        return (m_ph != 7) || (((m_t / FLASH_HALF) % 2) == 0);
    endfunction

    function automatic logic [2:0] exp_hw();
        case (m_ph)
            0:       return 3'b100;
            1:       return 3'b010;
            7:       return m_blink() ? 3'b010 : 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] exp_lr();
        case (m_ph)
            4:       return 3'b100;
            5:       return 3'b010;
            7:       return m_blink() ? 3'b001 : 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge();
        int  nph;
        bit  ncar, nped;
        int  done;
        if (!rst_n) begin
            m_ph = 0; m_t = 0; m_car = 1'b0; m_ped = 1'b0;
        end else if (flash && m_ph != 7) begin
            m_ph = 7; m_t = 0; m_car = 1'b0; m_ped = 1'b0;
        end else begin
            done = m_t + 1;   // cycles completed in this phase including this one
            nph = m_ph;
            case (m_ph)
                0: if (done >= HW_GREEN_MIN && (m_car || m_ped)) nph = 1;
                1: if (done == YELLOW) nph = 2;
                2: if (done == ALL_RED) nph = m_ped ? 3 : 4;
                3: if (done == WALK_LEN) nph = m_car ? 4 : 0;
                4: if (done == LR_GREEN_MAX || (done >= LR_GREEN_MIN && !lr_has_car)) nph = 5;
                5: if (done == YELLOW) nph = 6;
                6: if (done == ALL_RED) nph = 0;
                default: if (!flash) nph = 6;
            endcase
            ncar = m_car;
            if (lr_has_car && !(m_ph inside {4, 5, 7})) ncar = 1'b1;
            if (nph == 4 && m_ph != 4) ncar = 1'b0;
            nped = m_ped;
            if (ped_req && !(m_ph inside {3, 7})) nped = 1'b1;
            if (nph == 3 && m_ph != 3) nped = 1'b0;
            m_t   = (nph == m_ph) ? m_t + 1 : 0;
            m_ph  = nph;
            m_car = ncar;
            m_ped = nped;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("phase", {5'b0, phase}, 8'(m_ph));
        chk("hw_light", {5'b0, hw_light}, {5'b0, exp_hw()});
        chk("lr_light", {5'b0, lr_light}, {5'b0, exp_lr()});
        chk("walk", {7'b0, walk}, {7'b0, (m_ph == 3)});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_phase(input string tag, input int p);
        chk(tag, {5'b0, phase}, 8'(p));
    endtask

    task automatic do_reset();
        lr_has_car = 1'b0; ped_req = 1'b0; flash = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    int car_mode;

    initial begin
        // Reset state
        do_reset();
        do_reset();
        chk("rst_hw", {5'b0, hw_light}, 8'h04);
        chk("rst_lr", {5'b0, lr_light}, 8'h01);
        chk("rst_walk", {7'b0, walk}, 8'h00);
        expect_phase("rst_phase", 0);

        // Car held: full cycle 0,1,2,4,5,6,0 with default durations
        lr_has_car = 1'b1;
        run(69); expect_phase("s1_hwg_held", 0);
        run(1);  expect_phase("s1_hwy", 1);
        run(24); expect_phase("s1_hwy_held", 1);
        run(1);  expect_phase("s1_ar1", 2);
        run(1);  expect_phase("s1_lrg", 4);
        run(69); expect_phase("s1_lrg_held", 4);
        run(1);  expect_phase("s1_lry", 5);
        run(25); expect_phase("s1_ar2", 6);
        run(1);  expect_phase("s1_hwg_again", 0);

        // Single car pulse: gap-out after 10 cycles, then HW_G held indefinitely
        do_reset();
        run(10); lr_has_car = 1'b1; run(1); lr_has_car = 1'b0;
        run(58); expect_phase("s2_hwg_held", 0);
        run(1);  expect_phase("s2_hwy", 1);
        run(25); expect_phase("s2_ar1", 2);
        run(1);  expect_phase("s2_lrg", 4);
        run(9);  expect_phase("s2_lrg_held", 4);
        run(1);  expect_phase("s2_gapout", 5);
        run(25); expect_phase("s2_ar2", 6);
        run(1);  expect_phase("s2_hwg", 0);
        run(150); expect_phase("s2_hwg_idle", 0);

        // Pedestrian only: WALK for 30 cycles, then straight back to HW_G
        do_reset();
        run(5); ped_req = 1'b1; run(1); ped_req = 1'b0;
        run(63); expect_phase("s3_hwg_held", 0);
        run(1);  expect_phase("s3_hwy", 1);
        run(25); expect_phase("s3_ar1", 2);
        run(1);  expect_phase("s3_walk", 3);
        chk("s3_walk_lamp", {7'b0, walk}, 8'h01);
        chk("s3_walk_hw", {5'b0, hw_light}, 8'h01);
        chk("s3_walk_lr", {5'b0, lr_light}, 8'h01);
        run(29); expect_phase("s3_walk_held", 3);
        run(1);  expect_phase("s3_hwg", 0);
        run(100); expect_phase("s3_hwg_idle", 0);

        // Pedestrian and car: WALK then LR_G; a press during WALK is ignored
        do_reset();
        run(5); ped_req = 1'b1; lr_has_car = 1'b1; run(1); ped_req = 1'b0; lr_has_car = 1'b0;
        run(64); expect_phase("s4_hwy", 1);
        run(25); expect_phase("s4_ar1", 2);
        run(1);  expect_phase("s4_walk", 3);
        run(10); ped_req = 1'b1; run(1); ped_req = 1'b0;
        run(18); expect_phase("s4_walk_held", 3);
        run(1);  expect_phase("s4_lrg", 4);
        run(10); expect_phase("s4_lry", 5);
        run(26); expect_phase("s4_hwg", 0);
        run(100); expect_phase("s4_ped_ignored", 0);

        // Flash raised mid-LR_G, blinking every 50 cycles, then AR2 and HW_G
        do_reset();
        lr_has_car = 1'b1;
        run(96); expect_phase("s5_lrg", 4);
        run(5); flash = 1'b1;
        run(1);  expect_phase("s5_flash", 7);
        chk("s5_hw_on", {5'b0, hw_light}, 8'h02);
        chk("s5_lr_on", {5'b0, lr_light}, 8'h01);
        run(49); chk("s5_hw_on_held", {5'b0, hw_light}, 8'h02);
        run(1);  chk("s5_hw_off", {5'b0, hw_light}, 8'h00);
        chk("s5_lr_off", {5'b0, lr_light}, 8'h00);
        run(50); chk("s5_hw_on_again", {5'b0, hw_light}, 8'h02);
        flash = 1'b0;
        run(1);  expect_phase("s5_ar2", 6);
        run(1);  expect_phase("s5_hwg", 0);
        lr_has_car = 1'b0;

        // Reset during HW_Y clears requests and restarts at HW_G
        do_reset();
        lr_has_car = 1'b1;
        run(75); expect_phase("s6_hwy", 1);
        lr_has_car = 1'b0; rst_n = 1'b0;
        step(); rst_n = 1'b1;
        expect_phase("s6_rst_phase", 0);
        chk("s6_rst_hw", {5'b0, hw_light}, 8'h04);
        chk("s6_rst_lr", {5'b0, lr_light}, 8'h01);
        run(100); expect_phase("s6_req_cleared", 0);

        // Randomized traffic, pedestrians, flash and occasional reset
        do_reset();
        car_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 50 == 0) car_mode = int'($urandom_range(0, 2));
            case (car_mode)
                0:       lr_has_car = ($urandom_range(0, 19) == 0);
                1:       lr_has_car = $urandom_range(0, 1) == 1;
                default: lr_has_car = ($urandom_range(0, 19) != 0);
            endcase
            ped_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) flash = ~flash;
            rst_n = ($urandom_range(0, 799) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
